// File: rtl/duck_sprite_pkg.sv
// Shared sprite geometry, animation constants and ROM address helper
// for the duck sprite fetch pipeline.
package duck_sprite_pkg;

    localparam int SPRITE_W    = 56;
    localparam int SPRITE_H    = 56;
    localparam int FRAMES      = 3;
    localparam int FRAME_TICKS = 8;
    localparam int ADDR_W      = 14;

    localparam int FRAME_SIZE  = SPRITE_W * SPRITE_H;
    localparam int FRAME_IDX_W = $clog2(FRAMES);
    localparam int TICK_W      = $clog2(FRAME_TICKS);

    localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

    typedef logic [9:0] pix_coord_t;
    typedef logic [FRAME_IDX_W-1:0] frame_idx_t;

    // Frames sit back-to-back in the ROM, each stored row-major.
    function automatic logic [ADDR_W-1:0] sprite_addr(input frame_idx_t f,
                                                      input logic [10:0] dy,
                                                      input logic [10:0] dx);
        return ADDR_W'(32'(f) * 32'(FRAME_SIZE) + 32'(dy) * 32'(SPRITE_W) + 32'(dx));
    endfunction

endpackage

// File: rtl/duck_anim_counter.sv
// Animation sequencer: counts enabled frame_start pulses and steps the
// sprite frame index every FRAME_TICKS video frames.
module duck_anim_counter
    import duck_sprite_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_start,
    input  logic                   duck_en,
    output logic [FRAME_IDX_W-1:0] frame_idx
);

    logic [TICK_W-1:0]      tick_q, tick_d;
    logic [FRAME_IDX_W-1:0] frame_q, frame_d;

    // duck_en low freezes both counters so the animation resumes in place.
    always_comb begin
        tick_d  = tick_q;
        frame_d = frame_q;
        if (frame_start && duck_en) begin
            if (tick_q == TICK_W'(FRAME_TICKS - 1)) begin
                tick_d  = '0;
                frame_d = (frame_q == FRAME_IDX_W'(FRAMES - 1)) ? '0
                                                                 : frame_q + FRAME_IDX_W'(1);
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tick_q  <= '0;
            frame_q <= '0;
        end else begin
            tick_q  <= tick_d;
            frame_q <= frame_d;
        end
    end

    assign frame_idx = frame_q;

endmodule

// File: rtl/duck_sprite_fetch.sv
// Three-stage sprite fetch: box test and ROM address, ROM wait, then
// colour index capture with transparency-keyed hit flag.
module duck_sprite_fetch
    import duck_sprite_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic              pixel_valid_in,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        duck_x,
    input  logic [9:0]        duck_y,
    input  logic              duck_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        index,
    output logic              hit,
    output logic              pixel_valid_out
);

    logic [FRAME_IDX_W-1:0] frame_idx;

    duck_anim_counter u_anim (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .duck_en     (duck_en),
        .frame_idx   (frame_idx)
    );

    logic [10:0] draw_x_w, draw_y_w, x_lo, y_lo, x_hi, y_hi, dx, dy;
    logic        inbox_s0;

    // 11-bit bounds so a sprite hanging off the right/bottom edge never wraps.
    always_comb begin
        draw_x_w = {1'b0, DrawX};
        draw_y_w = {1'b0, DrawY};
        x_lo     = {1'b0, duck_x};
        y_lo     = {1'b0, duck_y};
        x_hi     = x_lo + 11'(SPRITE_W);
        y_hi     = y_lo + 11'(SPRITE_H);
        dx       = draw_x_w - x_lo;
        dy       = draw_y_w - y_lo;
        inbox_s0 = duck_en && pixel_valid_in
                   && (draw_x_w >= x_lo) && (draw_x_w < x_hi)
                   && (draw_y_w >= y_lo) && (draw_y_w < y_hi);
    end

    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              inbox1_q, inbox1_d, valid1_q, valid1_d;
    logic              inbox2_q, inbox2_d, valid2_q, valid2_d;
    logic [3:0]        index_q, index_d;
    logic              hit_q, hit_d, valid3_q, valid3_d;

    always_comb begin
        rom_addr_d = inbox_s0 ? sprite_addr(frame_idx, dy, dx) : '0;
        inbox1_d   = inbox_s0;
        valid1_d   = pixel_valid_in;
        inbox2_d   = inbox1_q;
        valid2_d   = valid1_q;
        index_d    = inbox2_q ? rom_data : TRANSPARENT_IDX;
        hit_d      = inbox2_q && (rom_data != TRANSPARENT_IDX);
        valid3_d   = valid2_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_addr_q <= '0;
            inbox1_q   <= 1'b0;
            valid1_q   <= 1'b0;
            inbox2_q   <= 1'b0;
            valid2_q   <= 1'b0;
            index_q    <= '0;
            hit_q      <= 1'b0;
            valid3_q   <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            inbox1_q   <= inbox1_d;
            valid1_q   <= valid1_d;
            inbox2_q   <= inbox2_d;
            valid2_q   <= valid2_d;
            index_q    <= index_d;
            hit_q      <= hit_d;
            valid3_q   <= valid3_d;
        end
    end

    assign rom_addr        = rom_addr_q;
    assign index           = index_q;
    assign hit             = hit_q;
    assign pixel_valid_out = valid3_q;

endmodule

// File: tb/tb_duck_sprite_fetch.sv
// Bench for duck_sprite_fetch: synchronous ROM model, per-cycle reference
// model comparison and directed literal checks.
module tb_duck_sprite_fetch;

    localparam int SW   = 56;
    localparam int SH   = 56;
    localparam int NFR  = 3;
    localparam int TICKS = 8;
    localparam int FSZ  = SW * SH;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        pixel_valid_in = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0, duck_x = '0, duck_y = '0;
    logic        duck_en = 1'b0;
    logic [13:0] rom_addr;
    logic [3:0]  rom_data = '0;
    logic [3:0]  index;
    logic        hit;
    logic        pixel_valid_out;

    duck_sprite_fetch dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .frame_start     (frame_start),
        .pixel_valid_in  (pixel_valid_in),
        .DrawX           (DrawX),
        .DrawY           (DrawY),
        .duck_x          (duck_x),
        .duck_y          (duck_y),
        .duck_en         (duck_en),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .index           (index),
        .hit             (hit),
        .pixel_valid_out (pixel_valid_out)
    );

    always #5 Clk = ~Clk;

    logic [3:0] rom_mem [0:16383];
    always @(posedge Clk) rom_data <= rom_mem[rom_addr];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: pixel in flight as (valid, inbox, addr); frame is
    // derived from the number of enabled frame_start pulses seen so far.
    typedef struct { bit valid; bit inbox; int addr; } stg_t;
    stg_t p1, p2, p3, s0;
    int   en_pulses;
    int   fr, px, py, bx, by;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            p1 = '{0, 0, 0};
            p2 = '{0, 0, 0};
            p3 = '{0, 0, 0};
            en_pulses = 0;
        end else begin
            fr = (en_pulses / TICKS) % NFR;
            px = int'(DrawX); py = int'(DrawY);
            bx = int'(duck_x); by = int'(duck_y);
            s0.valid = pixel_valid_in;
            s0.inbox = duck_en && pixel_valid_in && px >= bx && px < bx + SW
                       && py >= by && py < by + SH;
            s0.addr  = s0.inbox ? fr * FSZ + (py - by) * SW + (px - bx) : 0;
            p3 = p2; p2 = p1; p1 = s0;
            if (frame_start && duck_en) en_pulses++;
        end
    end

    always @(posedge Clk) begin
        #1;
        if (!Reset) begin
            chk("model_rom_addr", int'(rom_addr), p1.addr);
            chk("model_index", int'(index), p3.inbox ? int'(rom_mem[p3.addr]) : 0);
            chk("model_hit", int'(hit), int'(p3.inbox && rom_mem[p3.addr] != 4'h0));
            chk("model_pv_out", int'(pixel_valid_out), int'(p3.valid));
        end
    end

    task automatic one_pixel(input string name, input int x, input int y,
                             input int exp_addr, input int exp_idx, input int exp_hit);
        @(negedge Clk);
        DrawX = 10'(x); DrawY = 10'(y); pixel_valid_in = 1'b1;
        @(posedge Clk); #1;
        chk({name, "_addr"}, int'(rom_addr), exp_addr);
        @(negedge Clk);
        pixel_valid_in = 1'b0;
        @(posedge Clk); @(posedge Clk); #1;
        chk({name, "_index"}, int'(index), exp_idx);
        chk({name, "_hit"}, int'(hit), exp_hit);
        chk({name, "_pv"}, int'(pixel_valid_out), 1);
        @(negedge Clk); @(negedge Clk);
    endtask

    task automatic pulse_frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk); frame_start = 1'b1;
            @(negedge Clk); frame_start = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit found;
        for (int i = 0; i < 16384; i++) rom_mem[i] = 4'((i * 7 + i / 56) % 16);
        rom_mem[570] = 4'h3;
        rom_mem[23]  = 4'h9;
        for (int k = 0; k < 8; k++) begin
            rom_mem[k] = 4'h5; rom_mem[FSZ + k] = 4'h5; rom_mem[2 * FSZ + k] = 4'h5;
        end

        repeat (3) @(posedge Clk);
        #1;
        chk("reset_rom_addr", int'(rom_addr), 0);
        chk("reset_index", int'(index), 0);
        chk("reset_hit", int'(hit), 0);
        chk("reset_pv", int'(pixel_valid_out), 0);
        @(negedge Clk);
        Reset = 1'b0;
        duck_en = 1'b1; duck_x = 10'd100; duck_y = 10'd50;

        one_pixel("inside", 110, 60, 570, 3, 1);
        rom_mem[570] = 4'h0;
        one_pixel("transparent", 110, 60, 570, 0, 0);
        one_pixel("past_right", 156, 60, 0, 0, 0);
        one_pixel("last_col", 155, 60, 615, int'(rom_mem[615]), int'(rom_mem[615] != 0));
        one_pixel("past_bottom", 110, 106, 0, 0, 0);

        duck_x = 10'd1000;
        one_pixel("clip_right", 1023, 50, 23, 9, 1);
        one_pixel("clip_nowrap", 5, 50, 0, 0, 0);
        duck_x = 10'd100;

        // Seven pulses, then an eighth coincident with a pixel.
        pulse_frames(7);
        @(negedge Clk);
        frame_start = 1'b1; pixel_valid_in = 1'b1; DrawX = 10'd101; DrawY = 10'd50;
        @(posedge Clk); #1;
        chk("coincident_old_frame", int'(rom_addr), 1);
        @(negedge Clk);
        frame_start = 1'b0;
        @(posedge Clk); #1;
        chk("next_new_frame", int'(rom_addr), FSZ + 1);
        @(negedge Clk);
        pixel_valid_in = 1'b0;
        repeat (3) @(negedge Clk);
        one_pixel("frame1_origin", 100, 50, 3136, 5, 1);

        pulse_frames(16);
        one_pixel("frame_wrap", 101, 50, 1, 5, 1);
        duck_en = 1'b0;
        pulse_frames(8);
        one_pixel("disabled_nohit", 101, 50, 0, 0, 0);
        duck_en = 1'b1;
        one_pixel("held_frame", 101, 50, 1, 5, 1);

        // Continuous inbox stream, then reset mid-stream.
        @(negedge Clk);
        pixel_valid_in = 1'b1; DrawY = 10'd50;
        for (int k = 0; k < 5; k++) begin
            DrawX = 10'(100 + k);
            @(posedge Clk);
            @(negedge Clk);
        end
        chk("stream_hit_before_reset", int'(hit), 1);
        #2 Reset = 1'b1;
        #1;
        chk("async_rst_hit", int'(hit), 0);
        chk("async_rst_pv", int'(pixel_valid_out), 0);
        chk("async_rst_addr", int'(rom_addr), 0);
        chk("async_rst_index", int'(index), 0);
        @(negedge Clk);
        Reset = 1'b0; pixel_valid_in = 1'b0;
        @(negedge Clk);
        pixel_valid_in = 1'b1; DrawX = 10'd102;
        n = 0; found = 0;
        for (int c = 0; c < 8 && !found; c++) begin
            @(posedge Clk); #1;
            n++;
            if (pixel_valid_out) found = 1;
            @(negedge Clk);
            pixel_valid_in = 1'b0;
        end
        chk("first_valid_latency", n, 3);
        repeat (4) @(negedge Clk);

        for (int c = 0; c < 400; c++) begin
            @(negedge Clk);
            if ($urandom_range(0, 29) == 0) duck_x = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 29) == 0) duck_y = 10'($urandom_range(0, 1023));
            duck_en        = ($urandom_range(0, 9) != 0);
            frame_start    = ($urandom_range(0, 7) == 0);
            pixel_valid_in = ($urandom_range(0, 5) != 0);
            DrawX = 10'(int'(duck_x) + int'($urandom_range(0, 66)) - 5);
            DrawY = 10'(int'(duck_y) + int'($urandom_range(0, 66)) - 5);
        end
        @(negedge Clk);
        pixel_valid_in = 1'b0; frame_start = 1'b0;
        repeat (5) @(negedge Clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
